// File: rtl/wind_pattern_controller.sv
// Step sequencer for the 3-LED wind indicator: programmable-rate step tick,
// calm / right-to-left / left-to-right / freeze patterns, mode changes at boundaries.
module wind_pattern_controller #(
  parameter int CNT_W       = 32,
  parameter int DEFAULT_TAP = 25
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] mode,
  input  logic [4:0] rate_sel,
  input  logic       rate_load,
  input  logic       pause,
  output logic [2:0] leds,
  output logic       step_tick,
  output logic [1:0] mode_active,
  output logic       pending
);

  localparam logic [4:0] TAP_MAX   = 5'(CNT_W - 1);
  localparam logic [4:0] TAP_RESET = 5'(DEFAULT_TAP);

  typedef enum logic [3:0] {
    CALM_A, CALM_B, RL_0, RL_1, RL_2, LR_0, LR_1, LR_2, FREEZE
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [4:0]         tap_q, tap_d;
  logic               step_tick_q, step_tick_d;
  logic [2:0]         leds_q, leds_d;
  logic [1:0]         mode_active_q, mode_active_d;

  logic [CNT_W-1:0]   tap_bit;
  logic [CNT_W-1:0]   tap_mask;
  logic               cnt_match;
  logic               at_boundary;

  // Match when cnt[tap:0] == 1<<tap; mask wraps to all-ones when tap is the MSB.
  always_comb begin
    tap_bit   = CNT_W'(1) << tap_q;
    tap_mask  = (tap_bit << 1) - CNT_W'(1);
    cnt_match = ((cnt_q & tap_mask) == tap_bit);
  end

  always_comb begin
    at_boundary = (state_q == CALM_B) || (state_q == RL_2) ||
                  (state_q == LR_2)   || (state_q == FREEZE);
  end

  always_comb begin
    cnt_d         = cnt_q + CNT_W'(1);
    tap_d         = tap_q;
    step_tick_d   = cnt_match && !pause;
    state_d       = state_q;
    mode_active_d = mode_active_q;

    if (rate_load) begin
      tap_d = (rate_sel > TAP_MAX) ? TAP_MAX : rate_sel;
    end

    if (step_tick_q) begin
      if (at_boundary) begin
        mode_active_d = mode;
        case (mode)
          2'b00:   state_d = CALM_A;
          2'b01:   state_d = RL_0;
          2'b10:   state_d = LR_0;
          default: state_d = FREEZE;
        endcase
      end else begin
        case (state_q)
          CALM_A:  state_d = CALM_B;
          RL_0:    state_d = RL_1;
          RL_1:    state_d = RL_2;
          LR_0:    state_d = LR_1;
          LR_1:    state_d = LR_2;
          default: state_d = state_q;
        endcase
      end
    end
  end

  // FREEZE keeps whatever pattern was showing when it was entered.
  always_comb begin
    case (state_d)
      CALM_A:       leds_d = 3'b101;
      CALM_B:       leds_d = 3'b010;
      RL_0, LR_2:   leds_d = 3'b001;
      RL_1, LR_1:   leds_d = 3'b010;
      RL_2, LR_0:   leds_d = 3'b100;
      default:      leds_d = leds_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q         <= '0;
      tap_q         <= TAP_RESET;
      step_tick_q   <= 1'b0;
      state_q       <= CALM_A;
      leds_q        <= 3'b101;
      mode_active_q <= 2'b00;
    end else begin
      cnt_q         <= cnt_d;
      tap_q         <= tap_d;
      step_tick_q   <= step_tick_d;
      state_q       <= state_d;
      leds_q        <= leds_d;
      mode_active_q <= mode_active_d;
    end
  end

  assign leds        = leds_q;
  assign step_tick   = step_tick_q;
  assign mode_active = mode_active_q;
  assign pending     = (mode != mode_active_q);

endmodule

// File: tb/tb_wind_pattern_controller.sv
// Randomised bench for wind_pattern_controller against a sequence-position
// reference model (pattern tables indexed by mode and step position).
module tb_wind_pattern_controller;

  localparam int CNT_W = 8;
  localparam int DEF_TAP = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] mode = 2'b00;
  logic [4:0] rate_sel = 5'd0;
  logic       rate_load = 1'b0;
  logic       pause = 1'b0;
  logic [2:0] leds;
  logic       step_tick;
  logic [1:0] mode_active;
  logic       pending;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  int m_cnt, m_tap, m_mode, m_pos, m_leds;
  bit m_tick;

  wind_pattern_controller #(.CNT_W(CNT_W), .DEFAULT_TAP(DEF_TAP)) dut (
    .clk(clk), .reset(reset), .mode(mode), .rate_sel(rate_sel),
    .rate_load(rate_load), .pause(pause), .leds(leds), .step_tick(step_tick),
    .mode_active(mode_active), .pending(pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
    end
  endtask

  function automatic int pat(input int m, input int p);
    case (m)
      0:       return (p == 0) ? 5 : 2;
      1:       return (p == 0) ? 1 : (p == 1) ? 2 : 4;
      default: return (p == 0) ? 4 : (p == 1) ? 2 : 1;
    endcase
  endfunction

  function automatic bit model_match();
    return ((m_cnt % (1 << (m_tap + 1))) == (1 << m_tap));
  endfunction

  task automatic model_edge();
    bit nt;
    bit last;
    if (reset) begin
      m_cnt = 0; m_tap = DEF_TAP; m_tick = 0;
      m_mode = 0; m_pos = 0; m_leds = 5;
      return;
    end
    nt = model_match() && !pause;
    if (m_tick) begin
      last = (m_mode == 3) || (m_mode == 0 && m_pos == 1) ||
             (m_mode != 0 && m_pos == 2);
      if (last) begin
        m_mode = int'(mode);
        m_pos = 0;
        if (m_mode != 3) m_leds = pat(m_mode, 0);
      end else begin
        m_pos++;
        m_leds = pat(m_mode, m_pos);
      end
    end
    if (rate_load) m_tap = (int'(rate_sel) > CNT_W - 1) ? CNT_W - 1 : int'(rate_sel);
    m_cnt = (m_cnt + 1) % (1 << CNT_W);
    m_tick = nt;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    chk("leds", int'(leds), m_leds);
    chk("step_tick", int'(step_tick), int'(m_tick));
    chk("mode_active", int'(mode_active), m_mode);
    chk("pending", int'(pending), int'(mode != 2'(m_mode)));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic wait_for(input string tag, input int want_mode, input int want_leds);
    int k;
    k = 0;
    while (!(int'(mode_active) == want_mode && int'(leds) == want_leds) && k < 2000) begin
      cyc();
      k++;
    end
    if (k >= 2000) chk({tag, "_timeout"}, k, 0);
  endtask

  initial begin
    int n;
    // 1: reset and first tick latency
    reset = 1'b1;
    run(3);
    chk("reset_leds", int'(leds), 5);
    chk("reset_tick", int'(step_tick), 0);
    chk("reset_mode_active", int'(mode_active), 0);
    reset = 1'b0;
    n = 0;
    while (n < 20) begin
      cyc();
      n++;
      if (step_tick) break;
    end
    chk("first_tick_edge", n, 5);
    run(40);

    // 2: RL then request LR at RL_0
    mode = 2'b01;
    wait_for("rl0", 1, 1);
    mode = 2'b10;
    #0 chk("pending_set", int'(pending), 1);
    run(60);

    // 3: freeze from RL_1, then back to calm
    mode = 2'b01;
    wait_for("rl1", 1, 2);
    mode = 2'b11;
    run(50);
    chk("freeze_leds", int'(leds), 4);
    mode = 2'b00;
    run(24);

    // 4: tap clamp, fastest tap, rate_load on a tick cycle
    rate_sel = 5'd31; rate_load = 1'b1; cyc(); rate_load = 1'b0;
    run(600);
    rate_sel = 5'd0; rate_load = 1'b1; cyc(); rate_load = 1'b0;
    run(20);
    rate_sel = 5'd3; rate_load = 1'b1; cyc(); rate_load = 1'b0;
    n = 0;
    while (!model_match() && n < 100) begin cyc(); n++; end
    rate_sel = 5'd1; rate_load = 1'b1; cyc(); rate_load = 1'b0;
    chk("tick_with_load", int'(step_tick), 1);
    run(20);
    rate_sel = 5'd2; rate_load = 1'b1; cyc(); rate_load = 1'b0;

    // 5: pause mid-LR
    mode = 2'b10;
    wait_for("lr1p", 2, 2);
    run(3);
    pause = 1'b1;
    run(40);
    chk("pause_leds", int'(leds), 2);
    pause = 1'b0;
    run(30);

    // 6: reset at LR_1
    wait_for("lr1r", 2, 2);
    reset = 1'b1; cyc(); reset = 1'b0;
    chk("rst_leds", int'(leds), 5);
    chk("rst_mode_active", int'(mode_active), 0);
    run(30);

    // random phase
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 39) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 59) == 0) pause = ~pause;
      if ($urandom_range(0, 149) == 0) begin
        rate_sel = 5'($urandom_range(0, 4));
        if ($urandom_range(0, 9) == 0) rate_sel = 5'($urandom_range(0, 31));
        rate_load = 1'b1;
      end
      reset = ($urandom_range(0, 799) == 0);
      cyc();
      rate_load = 1'b0;
      reset = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
